// File: rtl/beamformer_pkg.sv
// Shared defaults, FSM encoding and width helpers for the beam scheduler slice.
// Every width is derived from the NUM_* parameters through these helpers.
package beamformer_pkg;

  localparam int unsigned DefNumChannels = 8;
  localparam int unsigned DefSampleWidth = 8;
  localparam int unsigned DefBufferDepth = 10;
  localparam int unsigned DefNumAngles   = 8;

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StRead = 1'b1;

  // Index width that stays at least one bit wide for degenerate sizes.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned tap_width(input int unsigned depth);
    return idx_width(depth);
  endfunction

  function automatic int unsigned beam_width(input int unsigned sw, input int unsigned nch);
    return sw + idx_width(nch);
  endfunction

endpackage

// File: rtl/beam_delay_lut.sv
// Delay tap lookup: tap = min(angle * channel, BUFFER_DEPTH - 1).
// The lookup is purely combinational.
module beam_delay_lut
  import beamformer_pkg::*;
#(
  parameter int unsigned NUM_CHANNELS = DefNumChannels,
  parameter int unsigned BUFFER_DEPTH = DefBufferDepth,
  parameter int unsigned NUM_ANGLES   = DefNumAngles
) (
  input  logic [idx_width(NUM_ANGLES)-1:0]   angle,
  input  logic [idx_width(NUM_CHANNELS)-1:0] channel,
  output logic [tap_width(BUFFER_DEPTH)-1:0] tap
);

  localparam int unsigned AW     = idx_width(NUM_ANGLES);
  localparam int unsigned CW     = idx_width(NUM_CHANNELS);
  localparam int unsigned TW     = tap_width(BUFFER_DEPTH);
  localparam int unsigned PW     = AW + CW;
  localparam int unsigned MaxTap = BUFFER_DEPTH - 1;

  logic [PW-1:0] prod;

  always_comb begin
    prod = PW'(angle) * PW'(channel);
    if (32'(prod) > MaxTap) begin
      tap = TW'(MaxTap);
    end else begin
      tap = TW'(prod);
    end
  end

endmodule

// File: rtl/beam_scheduler.sv
// Delay-and-sum beam scheduler: walks one channel per cycle through the shared
// buffer read port and accumulates the delayed samples into beam_out.
module beam_scheduler
  import beamformer_pkg::*;
#(
  parameter int unsigned NUM_CHANNELS = DefNumChannels,
  parameter int unsigned SAMPLE_WIDTH = DefSampleWidth,
  parameter int unsigned BUFFER_DEPTH = DefBufferDepth,
  parameter int unsigned NUM_ANGLES   = DefNumAngles
) (
  input  logic                                            clk,
  input  logic                                            reset,
  input  logic                                            frame_strobe,
  input  logic [idx_width(NUM_ANGLES)-1:0]                angle_in,
  input  logic                                            angle_load,
  input  logic                                            sweep_en,
  output logic [idx_width(NUM_CHANNELS)-1:0]              rd_channel,
  output logic [tap_width(BUFFER_DEPTH)-1:0]              rd_index,
  input  logic [SAMPLE_WIDTH-1:0]                         rd_sample,
  output logic [beam_width(SAMPLE_WIDTH, NUM_CHANNELS)-1:0] beam_out,
  output logic                                            beam_valid,
  output logic                                            busy,
  output logic [idx_width(NUM_ANGLES)-1:0]                cur_angle,
  output logic                                            overrun
);

  localparam int unsigned AW = idx_width(NUM_ANGLES);
  localparam int unsigned CW = idx_width(NUM_CHANNELS);
  localparam int unsigned TW = tap_width(BUFFER_DEPTH);
  localparam int unsigned BW = beam_width(SAMPLE_WIDTH, NUM_CHANNELS);

  logic [0:0]    state_q, state_d;
  logic [CW-1:0] counter_q, counter_d;
  logic [BW-1:0] acc_q, acc_d;
  logic [BW-1:0] beam_out_q, beam_out_d;
  logic          beam_valid_q, beam_valid_d;
  logic [AW-1:0] cur_angle_q, cur_angle_d;
  logic [AW-1:0] pending_q, pending_d;
  logic          overrun_q, overrun_d;

  logic [TW-1:0] tap;
  logic [BW-1:0] sum;
  logic [AW-1:0] next_angle;
  logic          last_read;

  beam_delay_lut #(
    .NUM_CHANNELS (NUM_CHANNELS),
    .BUFFER_DEPTH (BUFFER_DEPTH),
    .NUM_ANGLES   (NUM_ANGLES)
  ) u_delay_lut (
    .angle   (cur_angle_q),
    .channel (counter_q),
    .tap     (tap)
  );

  assign busy       = (state_q == StRead);
  assign rd_channel = busy ? counter_q : '0;
  assign rd_index   = busy ? tap : '0;
  assign sum        = acc_q + BW'(rd_sample);
  assign last_read  = (counter_q == CW'(NUM_CHANNELS - 1));
  assign next_angle = (cur_angle_q == AW'(NUM_ANGLES - 1)) ? '0 : cur_angle_q + AW'(1);

  always_comb begin
    state_d      = state_q;
    counter_d    = counter_q;
    acc_d        = acc_q;
    beam_out_d   = beam_out_q;
    beam_valid_d = 1'b0;
    cur_angle_d  = cur_angle_q;
    pending_d    = pending_q;
    overrun_d    = overrun_q;

    unique case (state_q)
      StIdle: begin
        if (frame_strobe) begin
          cur_angle_d = pending_q;
          acc_d       = '0;
          counter_d   = '0;
          state_d     = StRead;
        end
      end
      StRead: begin
        // Strobes are ignored for the whole frame, including its final read cycle.
        if (frame_strobe) begin
          overrun_d = 1'b1;
        end
        acc_d     = sum;
        counter_d = counter_q + CW'(1);
        if (last_read) begin
          beam_out_d   = sum;
          beam_valid_d = 1'b1;
          counter_d    = '0;
          state_d      = StIdle;
          if (sweep_en) begin
            pending_d = next_angle;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // An explicit load takes priority over the sweep increment.
    if (angle_load) begin
      pending_d = angle_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      counter_q    <= '0;
      acc_q        <= '0;
      beam_out_q   <= '0;
      beam_valid_q <= 1'b0;
      cur_angle_q  <= '0;
      pending_q    <= '0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      counter_q    <= counter_d;
      acc_q        <= acc_d;
      beam_out_q   <= beam_out_d;
      beam_valid_q <= beam_valid_d;
      cur_angle_q  <= cur_angle_d;
      pending_q    <= pending_d;
      overrun_q    <= overrun_d;
    end
  end

  assign beam_out   = beam_out_q;
  assign beam_valid = beam_valid_q;
  assign cur_angle  = cur_angle_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_beam_scheduler.sv
// Directed bench for beam_scheduler: a behavioural buffer model feeds rd_sample and
// expected beams are queued at each strobe, then compared when beam_valid fires.
module tb_beam_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic        frame_strobe;
  logic [2:0]  angle_in;
  logic        angle_load;
  logic        sweep_en;
  logic [2:0]  rd_channel;
  logic [3:0]  rd_index;
  logic [7:0]  rd_sample;
  logic [10:0] beam_out;
  logic        beam_valid;
  logic        busy;
  logic [2:0]  cur_angle;
  logic        overrun;

  typedef struct {
    int beam;
    int angle;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   smode  = 0;

  beam_scheduler dut (
    .clk          (clk),
    .reset        (reset),
    .frame_strobe (frame_strobe),
    .angle_in     (angle_in),
    .angle_load   (angle_load),
    .sweep_en     (sweep_en),
    .rd_channel   (rd_channel),
    .rd_index     (rd_index),
    .rd_sample    (rd_sample),
    .beam_out     (beam_out),
    .beam_valid   (beam_valid),
    .busy         (busy),
    .cur_angle    (cur_angle),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  // Buffer contents as a function of the read address, selected by smode.
  always_comb begin
    case (smode)
      0:       rd_sample = 8'd10;
      1:       rd_sample = 8'(rd_index);
      default: rd_sample = 8'(int'(rd_channel) * 3 + int'(rd_index));
    endcase
  end

  function automatic int tap_of(input int a, input int c);
    int p;
    p = a * c;
    return (p > 9) ? 9 : p;
  endfunction

  function automatic int sample_of(input int mode, input int c, input int t);
    if (mode == 0) return 10;
    if (mode == 1) return t;
    return c * 3 + t;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_beam_out"}, 32'(beam_out), 0);
    check({tag, "_beam_valid"}, 32'(beam_valid), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_cur_angle"}, 32'(cur_angle), 0);
    check({tag, "_overrun"}, 32'(overrun), 0);
    check({tag, "_rd_channel"}, 32'(rd_channel), 0);
    check({tag, "_rd_index"}, 32'(rd_index), 0);
  endtask

  // One frame at expected angle a; optional extra strobe / angle load during read n.
  task automatic do_frame(input int a, input int mode, input int strobe_at, input int load_at,
                          input int load_val);
    exp_t e;
    int   sum;
    sum   = 0;
    smode = mode;
    for (int c = 0; c < 8; c++) sum += sample_of(mode, c, tap_of(a, c));
    e.beam  = sum;
    e.angle = a;
    exp_q.push_back(e);
    frame_strobe = 1'b1;
    tick();
    frame_strobe = 1'b0;
    for (int n = 0; n < 8; n++) begin
      check("busy_read", 32'(busy), 1);
      check("rd_channel", 32'(rd_channel), n);
      check("rd_index", 32'(rd_index), tap_of(a, n));
      check("valid_early", 32'(beam_valid), 0);
      frame_strobe = (n == strobe_at);
      angle_load   = (n == load_at);
      angle_in     = 3'(load_val);
      tick();
      frame_strobe = 1'b0;
      angle_load   = 1'b0;
    end
    check("beam_valid", 32'(beam_valid), 1);
    check("exp_q_size", exp_q.size(), 1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("beam_out", 32'(beam_out), e.beam);
      check("cur_angle", 32'(cur_angle), e.angle);
    end
    check("busy_done", 32'(busy), 0);
    tick();
    check("valid_pulse", 32'(beam_valid), 0);
    check("idle_rd_channel", 32'(rd_channel), 0);
    check("idle_rd_index", 32'(rd_index), 0);
  endtask

  initial begin
    reset        = 1'b1;
    frame_strobe = 1'b0;
    angle_in     = '0;
    angle_load   = 1'b0;
    sweep_en     = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    check_idle_outputs("reset");

    // Angle 0, constant samples: sum of eight 10s.
    do_frame(0, 0, -1, -1, 0);

    // Angle 2, sample equals tap: clipped taps 0,2,4,6,8,9,9,9.
    angle_in   = 3'd2;
    angle_load = 1'b1;
    tick();
    angle_load = 1'b0;
    check("pending_not_cur", 32'(cur_angle), 0);
    do_frame(2, 1, -1, -1, 0);

    // Angle 1 with a second strobe at k+3 and a load of 5 at k+4.
    angle_in   = 3'd1;
    angle_load = 1'b1;
    tick();
    angle_load = 1'b0;
    do_frame(1, 2, 2, 3, 5);
    check("overrun_set", 32'(overrun), 1);
    repeat (4) begin
      tick();
      check("no_extra_frame", 32'(busy | beam_valid), 0);
    end
    do_frame(5, 2, -1, -1, 0);
    check("overrun_sticky", 32'(overrun), 1);

    // Strobe on the final read cycle counts as busy.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_idle_outputs("reset2");
    do_frame(0, 0, 7, -1, 0);
    check("overrun_exit", 32'(overrun), 1);
    check("exit_strobe_ignored", 32'(busy), 0);

    // Sweep from 7 wraps to 0; a load on the completion cycle beats the sweep.
    angle_in   = 3'd7;
    angle_load = 1'b1;
    tick();
    angle_load = 1'b0;
    sweep_en   = 1'b1;
    do_frame(7, 1, -1, -1, 0);
    do_frame(0, 2, -1, 7, 3);
    do_frame(3, 1, -1, -1, 0);
    sweep_en = 1'b0;
    do_frame(4, 1, -1, -1, 0);

    // Reset at k+4 aborts the frame without a beam_valid pulse.
    smode        = 0;
    frame_strobe = 1'b1;
    tick();
    frame_strobe = 1'b0;
    repeat (3) tick();
    check("abort_busy_before", 32'(busy), 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_idle_outputs("abort");
    repeat (10) begin
      tick();
      check("abort_no_valid", 32'(beam_valid), 0);
    end
    do_frame(0, 0, -1, -1, 0);
    check("exp_q_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/beam_scheduler.md
BEAM_SCHEDULER -- requirements
Module: beam_scheduler

Interface
REQ-001 The block SHALL have parameter NUM_CHANNELS, default 8, meaning the number of microphone channel buffers sequenced per frame.
REQ-002 The block SHALL have parameter SAMPLE_WIDTH, default 8, meaning the PCM sample width in bits.
REQ-003 The block SHALL have parameter BUFFER_DEPTH, default 10, meaning the samples held per channel buffer.
REQ-004 The block SHALL have parameter NUM_ANGLES, default 8, meaning the number of steering angles.
REQ-005 clk  in  1  clock; all logic on its rising edge.
REQ-006 reset  in  1  reset, synchronous, active-high.
REQ-007 frame_strobe  in  1  one-cycle pulse; new samples have been shifted into all channel buffers.
REQ-008 angle_in  in  clog2(NUM_ANGLES)  requested steering angle.
REQ-009 angle_load  in  1  pulse; capture angle_in into the pending-angle register.
REQ-010 sweep_en  in  1  when high, the angle advances by 1 after each completed frame.
REQ-011 rd_channel  out  clog2(NUM_CHANNELS)  selects the shared buffer read port.
REQ-012 rd_index  out  clog2(BUFFER_DEPTH)  delay tap presented to the selected buffer.
REQ-013 rd_sample  in  SAMPLE_WIDTH  unsigned buffer data, combinationally valid in the same cycle as rd_channel/rd_index.
REQ-014 beam_out  out  SAMPLE_WIDTH+clog2(NUM_CHANNELS)  delay-and-sum result, unsigned, held between frames.
REQ-015 beam_valid  out  1  one-cycle pulse; beam_out updated.
REQ-016 busy  out  1  high while in READ.
REQ-017 cur_angle  out  clog2(NUM_ANGLES)  angle used by the current or last frame.
REQ-018 overrun  out  1  sticky; set when frame_strobe arrives while busy.

Function
REQ-019 The FSM SHALL have two states: IDLE and READ.
REQ-020 In IDLE, a frame_strobe SHALL latch pending angle into cur_angle, clear the accumulator, set channel counter to 0, and enter READ.
REQ-021 In READ, each cycle the block SHALL drive rd_channel = counter, rd_index = delay(cur_angle, counter), add rd_sample to the accumulator, and increment the counter.
REQ-022 delay(a, c) SHALL equal min(a*c, BUFFER_DEPTH-1).
REQ-023 On the cycle with counter = NUM_CHANNELS-1, the block SHALL load beam_out with accumulator + rd_sample, pulse beam_valid in the following cycle, and return to IDLE.
REQ-024 Latency: strobe sampled at edge k; reads occur in cycles k+1..k+NUM_CHANNELS; beam_valid is high in cycle k+NUM_CHANNELS+1.
REQ-025 The accumulator SHALL be full width; no overflow is possible.
REQ-026 In IDLE, rd_channel and rd_index SHALL be 0.
REQ-027 A frame_strobe while busy SHALL be ignored and SHALL set overrun; the frame in progress completes unaffected.
REQ-028 A frame_strobe in the same cycle that READ exits SHALL be treated as busy, setting overrun.
REQ-029 angle_load SHALL update only the pending angle; cur_angle SHALL change only at frame start.
REQ-030 At frame completion with sweep_en high, pending angle SHALL become cur_angle+1, wrapping NUM_ANGLES-1 to 0.
REQ-031 When angle_load coincides with a sweep increment, angle_load SHALL win.

Reset
REQ-032 Reset SHALL force state IDLE; beam_out, beam_valid, busy, cur_angle, pending angle, counter, accumulator, and overrun to 0.
REQ-033 Reset SHALL abort a frame mid-READ with no beam_valid pulse.

Structure
REQ-034 Default parameters, the state encoding, and the delay-width formulas SHALL reside in shared package beamformer_pkg.
REQ-035 delay() SHALL be implemented in sub-module beam_delay_lut, a combinational block with inputs angle and channel and output tap.

Verification
REQ-036 Angle 0, rd_sample constant 10 -> all rd_index = 0; beam_out = 80, beam_valid at k+9.
REQ-037 Angle 2, rd_sample = rd_index -> taps 0,2,4,6,8,9,9,9; beam_out = 47.
REQ-038 frame_strobe at k and k+3 -> one beam_valid; overrun = 1 until reset.
REQ-039 angle_load=5 at k+4 during a frame at angle 1 -> current frame uses angle 1; next frame uses cur_angle 5.
REQ-040 sweep_en=1 from angle 7 over two frames -> cur_angle sequence 7, 0.
REQ-041 reset at k+4 mid-frame -> no beam_valid; all outputs 0; next strobe produces a normal result.
